hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage core. It sits beside the ID stage and tracks destination registers of in-flight instructions in EX, MEM and WB. From that it produces stall and bubble controls for read-after-write hazards, flush controls for taken branches, and drains the pipeline into a sticky halted state on HALT.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/hazard_ctrl_if.sv | 24 ++
 rtl/hz_decode.sv | 66 ++++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: ISA opcodes, hazard scoreboard slot, controller state.
package pipe_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000,
    OP_ADDI = 6'b000001,
    OP_SUB  = 6'b000010,
    OP_SUBI = 6'b000011,
    OP_MUL  = 6'b000100,
    OP_MULI = 6'b000101,
    OP_OR   = 6'b000110,
    OP_ORI  = 6'b000111,
    OP_AND  = 6'b001000,
    OP_ANDI = 6'b001001,
    OP_XOR  = 6'b001010,
    OP_XORI = 6'b001011,
    OP_LDW  = 6'b001100,
    OP_STW  = 6'b001101,
    OP_BZ   = 6'b001110,
    OP_BEQ  = 6'b001111,
    OP_JR   = 6'b010000,
    OP_HALT = 6'b010001
  } opcode_t;

  // One in-flight instruction: valid means an instruction occupies the
  // stage; dest is REG_ZERO when it writes no register.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } hz_slot_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard controller bus: the pipeline (master) presents the ID
// instruction and branch outcome, the controller (slave) returns controls.
interface hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            inst_id;
  logic                   inst_valid_id;
  logic                   br_taken_ex;
  logic                   stall_if;
  logic                   bubble_ex;
  logic                   flush_id;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output inst_id, inst_valid_id, br_taken_ex,
    input  stall_if, bubble_ex, flush_id, halted, stall_cnt
  );

  modport slave (
    input  inst_id, inst_valid_id, br_taken_ex,
    output stall_if, bubble_ex, flush_id, halted, stall_cnt
  );
endinterface

// File: rtl/hz_decode.sv
// Register-usage decode of the ID instruction: which sources it reads,
// which register it writes, and whether it is a load or HALT.
module hz_decode
  import pipe_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  src1,
  output logic        src1_valid,
  output logic [4:0]  src2,
  output logic        src2_valid,
  output logic [4:0]  dest,
  output logic        dest_valid,
  output logic        is_load,
  output logic        is_halt
);

  logic [5:0] op;
  logic       use_rs;
  logic       use_rt;
  logic       unused_imm;

  assign op         = inst[31:26];
  assign unused_imm = ^inst[10:0];

  // Classify the opcode; register 0 is masked out of every source and dest.
  always_comb begin
    src1    = inst[25:21];
    src2    = inst[20:16];
    dest    = REG_ZERO;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dest   = inst[15:11];
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        use_rs = 1'b1;
        dest   = inst[20:16];
      end
      OP_LDW: begin
        use_rs  = 1'b1;
        dest    = inst[20:16];
        is_load = 1'b1;
      end
      OP_STW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BZ, OP_JR: begin
        use_rs = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: ;
    endcase
    src1_valid = use_rs && (src1 != REG_ZERO);
    src2_valid = use_rt && (src2 != REG_ZERO);
    dest_valid = (dest != REG_ZERO);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / sequencing controller beside the ID stage.
// Tracks EX/MEM/WB destinations, stalls on RAW hazards, flushes on taken
// branches and drains into a sticky halted state on HALT.
// Build option: define HZ_FORWARDING_EN when the EX->ID forwarding network
// exists; only load-use against the EX slot then raises a hazard.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic [4:0]             src1, src2, dest;
  logic                   src1_valid, src2_valid, dest_valid;
  logic                   is_load, is_halt;
  logic                   s1_live, s2_live;
  logic [2:0]             slot_match;
  logic                   hazard, issue, count_stall, slots_empty;
  logic                   stall_if, bubble_ex, flush_id;
  logic                   unused_bits;
  hz_slot_t               slot_q [3];
  hz_slot_t               slot_d [3];
  hz_state_t              state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hz_decode u_decode (
    .inst       (hz.inst_id),
    .src1       (src1),
    .src1_valid (src1_valid),
    .src2       (src2),
    .src2_valid (src2_valid),
    .dest       (dest),
    .dest_valid (dest_valid),
    .is_load    (is_load),
    .is_halt    (is_halt)
  );

  assign s1_live = hz.inst_valid_id && src1_valid;
  assign s2_live = hz.inst_valid_id && src2_valid;

  // Per-slot source/dest compare; no-dest slots hold REG_ZERO and never match.
  for (genvar gi = 0; gi < 3; gi++) begin : g_match
    assign slot_match[gi] = slot_q[gi].valid &&
                            ((s1_live && (src1 == slot_q[gi].dest)) ||
                             (s2_live && (src2 == slot_q[gi].dest)));
  end

`ifdef HZ_FORWARDING_EN
  assign hazard      = slot_match[0] && slot_q[0].is_load;
  assign unused_bits = ^{slot_match[2:1], slot_q[1].is_load, slot_q[2].is_load};
`else
  assign hazard      = |slot_match;
  assign unused_bits = ^{slot_q[0].is_load, slot_q[1].is_load, slot_q[2].is_load};
`endif

  assign issue       = hz.inst_valid_id && !hazard && !hz.br_taken_ex && (state_q == RUN);
  assign count_stall = (state_q == RUN) && !hz.br_taken_ex && hazard;
  assign slots_empty = !slot_q[0].valid && !slot_q[1].valid && !slot_q[2].valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: an issued HALT starts the drain; HALTED is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (issue && is_halt) state_d = DRAIN;
      DRAIN:   if (slots_empty)      state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Pipeline controls: flush beats hazard in RUN; DRAIN/HALTED freeze the front end.
  always_comb begin
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (hz.br_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (hazard) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        DRAIN, HALTED: begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard shift and saturating hazard-stall counter.
  always_comb begin
    slot_d[0] = '0;
    if (issue) begin
      slot_d[0].valid   = 1'b1;
      slot_d[0].dest    = dest_valid ? dest : REG_ZERO;
      slot_d[0].is_load = is_load;
    end
    slot_d[1] = slot_q[0];
    slot_d[2] = slot_q[1];
    stall_cnt_d = stall_cnt_q;
    if (count_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_if  = stall_if;
  assign hz.bubble_ex = bubble_ex;
  assign hz.flush_id  = flush_id;
  assign hz.halted    = (state_q == HALTED);
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle pushes the expected controls
// {stall_if, bubble_ex, flush_id, halted} and stall_cnt, then pops and compares.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hazard_ctrl_if #(.STALL_CNT_W(CW)) bus ();
  hazard_ctrl #(.STALL_CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] r_op(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [3:0] obs_flags();
    return {bus.stall_if, bus.bubble_ex, bus.flush_id, bus.halted};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic v, input logic br);
    bus.inst_id       = inst;
    bus.inst_valid_id = v;
    bus.br_taken_ex   = br;
  endtask

  task automatic push(input logic [3:0] f, input int c);
    exp_t e;
    e.flags = f;
    e.cnt   = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    drive(r_op(OP_ADD, 1, 2, 3), 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    push(4'b0000, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_flags() !== e.flags) $display("FAIL reset_flags: got %b want %b", obs_flags(), e.flags);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL reset_cnt: got %0d want %0d", bus.stall_cnt, e.cnt);
    else n_pass++;
    $display("reset: flags=%b cnt=%0d", obs_flags(), bus.stall_cnt);
  endtask

  task automatic test_raw();
    logic [31:0] inst_t [6];
    int val_t [6];
    int f_t [6];
    int c_t [6];
    exp_t e;
    do_reset();
    inst_t = '{r_op(OP_ADD, 1, 2, 3), r_op(OP_ADD, 3, 1, 4), r_op(OP_ADD, 3, 1, 4),
               r_op(OP_ADD, 3, 1, 4), r_op(OP_ADD, 3, 1, 4), 32'd0};
`ifdef HZ_FORWARDING_EN
    val_t = '{1, 1, 0, 0, 0, 0};
    f_t   = '{0, 0, 0, 0, 0, 0};
    c_t   = '{0, 0, 0, 0, 0, 0};
`else
    val_t = '{1, 1, 1, 1, 1, 0};
    f_t   = '{0, 12, 12, 12, 0, 0};
    c_t   = '{0, 0, 1, 2, 3, 3};
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(inst_t[i], val_t[i][0], 1'b0);
      push(f_t[i][3:0], c_t[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL raw_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL raw_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("raw cyc %0d: inst=%h flags=%b cnt=%0d", i, inst_t[i], obs_flags(), bus.stall_cnt);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] inst_t [5];
    int val_t [5];
    int f_t [5];
    int c_t [5];
    exp_t e;
    do_reset();
    inst_t = '{i_op(OP_LDW, 1, 5, 8), r_op(OP_ADD, 5, 1, 6), r_op(OP_ADD, 5, 1, 6),
               r_op(OP_ADD, 5, 1, 6), r_op(OP_ADD, 5, 1, 6)};
`ifdef HZ_FORWARDING_EN
    val_t = '{1, 1, 1, 0, 0};
    f_t   = '{0, 12, 0, 0, 0};
    c_t   = '{0, 0, 1, 1, 1};
`else
    val_t = '{1, 1, 1, 1, 1};
    f_t   = '{0, 12, 12, 12, 0};
    c_t   = '{0, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(inst_t[i], val_t[i][0], 1'b0);
      push(f_t[i][3:0], c_t[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL load_use_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL load_use_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("load_use cyc %0d: inst=%h flags=%b cnt=%0d", i, inst_t[i], obs_flags(), bus.stall_cnt);
    end
  endtask

  task automatic test_reg_zero();
    logic [31:0] inst_t [4];
    int val_t [4];
    exp_t e;
    do_reset();
    inst_t = '{i_op(OP_ADDI, 0, 0, 5), r_op(OP_ADD, 0, 0, 7), r_op(OP_STW, 0, 0, 0), 32'd0};
    val_t  = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(inst_t[i], val_t[i][0], 1'b0);
      push(4'b0000, 0);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL reg_zero_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL reg_zero_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("reg_zero cyc %0d: inst=%h flags=%b cnt=%0d", i, inst_t[i], obs_flags(), bus.stall_cnt);
    end
  endtask

  task automatic test_flush();
    logic [31:0] inst_t [7];
    int val_t [7];
    int br_t [7];
    int f_t [7];
    int c_t [7];
    exp_t e;
    do_reset();
`ifdef HZ_FORWARDING_EN
    inst_t = '{r_op(OP_ADD, 1, 2, 3), r_op(OP_ADD, 3, 1, 4), r_op(OP_ADD, 4, 4, 5),
               r_op(OP_ADD, 3, 3, 9), 32'd0, r_op(OP_HALT, 0, 0, 0), 32'd0};
    val_t  = '{1, 1, 1, 1, 0, 1, 0};
    br_t   = '{0, 1, 0, 0, 0, 1, 0};
    f_t    = '{0, 6, 0, 0, 0, 6, 0};
    c_t    = '{0, 0, 0, 0, 0, 0, 0};
`else
    inst_t = '{r_op(OP_ADD, 1, 2, 3), r_op(OP_ADD, 3, 1, 4), r_op(OP_ADD, 4, 4, 5),
               r_op(OP_ADD, 3, 3, 9), r_op(OP_ADD, 3, 3, 9), r_op(OP_HALT, 0, 0, 0), 32'd0};
    val_t  = '{1, 1, 1, 1, 1, 1, 0};
    br_t   = '{0, 1, 0, 0, 0, 1, 0};
    f_t    = '{0, 6, 0, 12, 0, 6, 0};
    c_t    = '{0, 0, 0, 0, 1, 1, 1};
`endif
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(inst_t[i], val_t[i][0], br_t[i][0]);
      push(f_t[i][3:0], c_t[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL flush_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL flush_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("flush cyc %0d: inst=%h br=%0d flags=%b cnt=%0d", i, inst_t[i], br_t[i], obs_flags(), bus.stall_cnt);
    end
  endtask

  task automatic test_halt_drain();
    logic [31:0] inst;
    logic [3:0]  f;
    exp_t e;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      if (i == 0)      inst = i_op(OP_LDW, 1, 2, 0);
      else if (i == 1) inst = r_op(OP_HALT, 0, 0, 0);
      else             inst = r_op(OP_ADD, 2, 2, 4);
      if (i < 2)       f = 4'b0000;
      else if (i < 6)  f = 4'b1100;
      else             f = 4'b1101;
      @(posedge clk); #1;
      drive(inst, 1'b1, 1'b0);
      push(f, 0);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL halt_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL halt_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("halt cyc %0d: inst=%h flags=%b cnt=%0d", i, inst, obs_flags(), bus.stall_cnt);
    end
  endtask

  task automatic test_reset_drain();
    logic [31:0] inst_t [8];
    int f_t [8];
    int c_t [8];
    int n;
    int s;
    exp_t e;
`ifdef HZ_FORWARDING_EN
    s = 1;
`else
    s = 3;
`endif
    do_reset();
    // LDW r5, then dependent ADD (stalls s cycles, then issues), HALT, one drain cycle.
    inst_t[0] = i_op(OP_LDW, 1, 5, 0);
    f_t[0] = 0;
    c_t[0] = 0;
    for (int k = 0; k <= s; k++) begin
      inst_t[1+k] = r_op(OP_ADD, 5, 1, 6);
      f_t[1+k]    = (k < s) ? 12 : 0;
      c_t[1+k]    = k;
    end
    inst_t[s+2] = r_op(OP_HALT, 0, 0, 0);
    f_t[s+2]    = 0;
    c_t[s+2]    = s;
    inst_t[s+3] = r_op(OP_ADD, 6, 6, 7);
    f_t[s+3]    = 12;
    c_t[s+3]    = s;
    n = s + 4;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(inst_t[i], 1'b1, 1'b0);
      push(f_t[i][3:0], c_t[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL rst_drain_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL rst_drain_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("rst_drain cyc %0d: inst=%h flags=%b cnt=%0d", i, inst_t[i], obs_flags(), bus.stall_cnt);
    end
    // Mid-DRAIN reset must clear outputs at once, without waiting for an edge.
    reset = 1'b1;
    #1;
    push(4'b0000, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_flags() !== e.flags) $display("FAIL rst_drain_async_flags: got %b want %b", obs_flags(), e.flags);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL rst_drain_async_cnt: got %0d want %0d", bus.stall_cnt, e.cnt);
    else n_pass++;
    $display("rst_drain async: flags=%b cnt=%0d", obs_flags(), bus.stall_cnt);
    @(posedge clk); #1;
    reset = 1'b0;
    // Back in RUN with empty slots: first ADD issues, dependent one behaves normally.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive(r_op(OP_ADD, 1, 2, 7), 1'b1, 1'b0);
        push(4'b0000, 0);
      end else begin
        drive(r_op(OP_ADD, 7, 7, 8), 1'b1, 1'b0);
`ifdef HZ_FORWARDING_EN
        push(4'b0000, 0);
`else
        push(4'b1100, 0);
`endif
      end
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_flags() !== e.flags) $display("FAIL rst_after_flags cyc %0d: got %b want %b", i, obs_flags(), e.flags);
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== e.cnt[CW-1:0]) $display("FAIL rst_after_cnt cyc %0d: got %0d want %0d", i, bus.stall_cnt, e.cnt);
      else n_pass++;
      $display("rst_after cyc %0d: flags=%b cnt=%0d", i, obs_flags(), bus.stall_cnt);
    end
  endtask

  initial begin
    drive(32'd0, 1'b0, 1'b0);
    test_reset();
    test_raw();
    test_load_use();
    test_reg_zero();
    test_flush();
    test_halt_drain();
    test_reset_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
